// File: rtl/seq_divider_if.sv
// Start/Done handshake and operand/result bus for the sequential divider.
`timescale 1ns/1ps
interface seq_divider_if #(
   parameter int unsigned k = 16
);
   logic [k-1:0] A;
   logic [k-1:0] B;
   logic         Start;
   logic         Done;
   logic [k-1:0] Q;
   logic [k-1:0] R;
   logic         DivByZero;

   modport master (
      output A, B, Start,
      input  Done, Q, R, DivByZero
   );

   modport slave (
      input  A, B, Start,
      output Done, Q, R, DivByZero
   );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock, Start/Done handshake.
`timescale 1ns/1ps
module seq_divider #(
   parameter int unsigned k = 16
) (
   input logic          clk,
   input logic          reset,
   seq_divider_if.slave bus
);

   localparam int unsigned CntW = (k > 1) ? $clog2(k) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [k-1:0]    d_q, d_d;      // dividend shifting out, quotient shifting in
   logic [k-1:0]    v_q, v_d;      // captured divisor
   logic [k:0]      p_q, p_d;      // partial remainder, one guard bit
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            last_q, last_d; // all k steps done, next edge publishes the result
   logic [k-1:0]    q_q, q_d;
   logic [k-1:0]    r_q, r_d;
   logic            dz_q, dz_d;
   logic            done_q, done_d;

   logic [k:0]      p_shift;
   logic [k:0]      p_step;
   logic [k-1:0]    d_step;
   logic            fits;

   // One restoring step: shift in the next dividend bit and subtract when the divisor fits.
   always_comb begin
      p_shift = {p_q[k-1:0], d_q[k-1]};
      fits    = (p_shift >= {1'b0, v_q});
      p_step  = fits ? (p_shift - {1'b0, v_q}) : p_shift;
      d_step  = {d_q[k-2:0], fits};
   end

   // Next-state logic for the IDLE/CALC/DONE controller and datapath.
   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      v_d     = v_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      done_d  = done_q;
      unique case (state_q)
         StIdle: begin
            if (bus.Start) begin
               d_d     = bus.A;
               v_d     = bus.B;
               p_d     = '0;
               cnt_d   = CntW'(k - 1);
               last_d  = 1'b0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            if (last_q) begin
               q_d     = d_q;
               r_d     = p_q[k-1:0];
               dz_d    = (v_q == '0);
               done_d  = 1'b1;
               last_d  = 1'b0;
               state_d = StDone;
            end else begin
               p_d = p_step;
               d_d = d_step;
               if (cnt_q == '0) begin
                  last_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         StDone: begin
            // Start must drop for an edge before another operation is accepted.
            if (!bus.Start) begin
               done_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            done_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // State registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         d_q     <= '0;
         v_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         v_q     <= v_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
      end
   end

   assign bus.Done      = done_q;
   assign bus.Q         = q_q;
   assign bus.R         = r_q;
   assign bus.DivByZero = dz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring unsigned integer divider, k-bit dividend and divisor. Produces a k-bit quotient and a k-bit remainder.
- Inverse-operation companion to the team's sequential Start/Done multiplier datapath. Uses the same Start/Done handshake so the same bench style and controllers can drive it.
- Computes one quotient bit per clock.

Parameters:
k, 16, operand/result width in bits (k >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
A  input  k  dividend, unsigned; sampled only when a Start is accepted
B  input  k  divisor, unsigned; sampled only when a Start is accepted
Start  input  1  level request; accepted in IDLE when high
Done  output  1  high while result is valid (DONE state)
Q  output  k  quotient, registered
R  output  k  remainder, registered
DivByZero  output  1  high with Done when the captured B was 0

Behaviour:
- Reset: one clock; reset is asynchronous and active-high, and the ports are named clk and reset. Reset forces state=IDLE, Done=0, Q=0, R=0, DivByZero=0, and clears all internal registers. Asserting reset mid-division aborts the operation; no partial result is ever presented.
- States: IDLE, CALC, DONE.
- IDLE:
  - If Start=1 at a rising edge, the block latches dividend register D<=A and divisor register V<=B.
  - It also clears the partial remainder P (k+1 bits) to 0, sets the iteration counter to k-1, and moves to CALC.
  - If Start=0, it stays in IDLE.
- CALC, each cycle:
  - P' = {P[k-1:0], D[k-1]}; D <= D<<1.
  - If P' >= {1'b0,V}: P <= P'-V and the shifted-in D[0] <= 1. Else: P <= P' and D[0] <= 0.
  - Comparison and subtraction use k+1 bits; no truncation before the compare.
  - When counter==0 after the step, go to DONE. Otherwise decrement the counter.
  - Exactly k CALC cycles are performed.
- Transition to DONE:
  - Q <= final D (quotient) and R <= final P[k-1:0].
  - DivByZero <= (V==0). Done <= 1 in the same edge.
- Latency: a Start accepted at edge 0 gives Done high after edge k+1 (k=16: 17 cycles). This is fixed and independent of operand values, including B=0.
- DONE:
  - Done stays high, and Q/R/DivByZero hold, for as long as Start=1.
  - When Start=0 at a rising edge: go to IDLE and Done<=0. Q/R/DivByZero keep the last result until the next DONE entry.
  - Start held high continuously yields exactly one operation per Start assertion; a new operation needs Start low for at least one edge.
- Start and A/B changes during CALC or DONE are ignored.
- Divide by zero: no special path. The restoring algorithm naturally yields Q = all ones and R = A. DivByZero=1 is the flag.
- Q and R never change outside the CALC->DONE transition or reset.

Test Plan:
- 100/7: A=100, B=7, Start held high -> Done rises exactly 17 cycles after the Start edge; Q=14, R=2, DivByZero=0. Q/R hold until Start drops.
- Boundary values, one operation each:
  - A=65535, B=1 -> Q=65535, R=0.
  - A=3, B=10 -> Q=0, R=3.
  - A=65535, B=65535 -> Q=1, R=0.
- Divide by zero: A=1234, B=0 -> after 17 cycles Q=65535, R=1234, DivByZero=1, Done=1.
- Handshake:
  - Keep Start=1 for 40 cycles after Done -> Done stays 1 and no second operation starts (Q/R unchanged even if A/B change).
  - Drop Start for one edge -> Done=0 next edge.
  - Re-raise Start with A=50, B=6 -> Q=8, R=2 after 17 cycles.
- Reset mid-operation: start A=1000, B=3, assert reset asynchronously at cycle 8 -> Done, Q, R, DivByZero go 0 immediately without a clock edge. After release with Start=1, A=1000, B=3 -> Q=333, R=1 after 17 cycles.
- Randomised sweep (file-driven vectors A, B, expected Q, expected R, in the team's bench format) -> every checked Q/R matches A/B and A%B at Done.
